// File: rtl/pe2ddr_sched.sv
// pe2ddr_sched: splits one PE-result write-back command into packer
// transfer segments and issues them one at a time.
//   Segment order: abuf data per group, abuf tail per group, bbuf data,
//   bbuf tail; empty segments are skipped.
//   For each segment: DDR write-address request, then a one-cycle packer
//   start, then wait for the packer done level.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_layer_type..cmd_base    command fields, latched on accept
//   cmd_done                    one-cycle pulse when the command finishes
//   pe_start/pe_done            packer start pulse / done level
//   conf_*                      packer configuration for the current segment
//   waddr/wlen/waddr_valid/waddr_ready  DDR write-address request channel
module pe2ddr_sched #(
  parameter int ADDR_W  = 32,
  parameter int NUM_W   = 8,
  parameter int MAX_GRP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_layer_type,
  input  logic [2:0]        cmd_grp_num,
  input  logic [NUM_W-1:0]  cmd_a_num,
  input  logic [NUM_W-1:0]  cmd_at_num,
  input  logic [NUM_W-1:0]  cmd_b_num,
  input  logic [NUM_W-1:0]  cmd_bt_num,
  input  logic [ADDR_W-1:0] cmd_base,
  output logic              cmd_done,
  output logic              pe_start,
  input  logic              pe_done,
  output logic [3:0]        conf_layer_type,
  output logic [1:0]        conf_trans_type,
  output logic [NUM_W-1:0]  conf_trans_num,
  output logic [1:0]        conf_grp_sel,
  output logic [ADDR_W-1:0] waddr,
  output logic [NUM_W-1:0]  wlen,
  output logic              waddr_valid,
  input  logic              waddr_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_START, S_WAIT0, S_WAIT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]        grp_num_q;
  logic [NUM_W-1:0]  a_num_q, at_num_q, b_num_q, bt_num_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] offset;

  // Effective group count: per-group layers emit grp_num groups (clamped to
  // the number of abuf groups), summing layers emit a single group 0.
  function automatic logic [2:0] eff_grp(input logic per_grp, input logic [2:0] n);
    if (!per_grp)
      return 3'd1;
    if (n > 3'(MAX_GRP))
      return 3'(MAX_GRP);
    return n;
  endfunction

  // Finds the first non-empty segment at or after position (t_in, g_in).
  // Result: {found, trans_type[1:0], grp[1:0]}.
  function automatic logic [4:0] pick(
    input logic [2:0] t_in,
    input logic [2:0] g_in,
    input logic [2:0] g_cnt,
    input logic       a_nz,
    input logic       at_nz,
    input logic       b_nz,
    input logic       bt_nz
  );
    logic [2:0] t;
    logic [2:0] g;
    logic [4:0] r;
    t = t_in;
    g = g_in;
    r = '0;
    if (t == 3'd0) begin
      if (a_nz && (g < g_cnt)) r = {1'b1, 2'd0, g[1:0]};
      else begin
        t = 3'd1;
        g = '0;
      end
    end
    if (!r[4] && (t == 3'd1)) begin
      if (at_nz && (g < g_cnt)) r = {1'b1, 2'd1, g[1:0]};
      else t = 3'd2;
    end
    if (!r[4] && (t == 3'd2)) begin
      if (b_nz) r = {1'b1, 2'd2, 2'd0};
      else t = 3'd3;
    end
    if (!r[4] && (t == 3'd3)) begin
      if (bt_nz) r = {1'b1, 2'd3, 2'd0};
    end
    return r;
  endfunction

  function automatic logic [NUM_W-1:0] seg_num(
    input logic [1:0]       t,
    input logic [NUM_W-1:0] a,
    input logic [NUM_W-1:0] at,
    input logic [NUM_W-1:0] b,
    input logic [NUM_W-1:0] bt
  );
    case (t)
      2'd0:    return a;
      2'd1:    return at;
      2'd2:    return b;
      default: return bt;
    endcase
  endfunction

  logic [4:0]        cap_pick;
  logic [4:0]        adv_pick;
  logic [2:0]        adv_t;
  logic [2:0]        adv_g;
  logic [NUM_W-1:0]  cap_num;
  logic [NUM_W-1:0]  adv_num;
  logic [ADDR_W-1:0] offset_nxt;

  always_comb begin
    cap_pick = pick(3'd0, 3'd0, eff_grp(cmd_layer_type[0], cmd_grp_num),
                    cmd_a_num != '0, cmd_at_num != '0,
                    cmd_b_num != '0, cmd_bt_num != '0);
    cap_num  = seg_num(cap_pick[3:2], cmd_a_num, cmd_at_num, cmd_b_num, cmd_bt_num);

    // Per-group segment types step the group; bbuf segments step the type.
    if (conf_trans_type[1] == 1'b0) begin
      adv_t = {1'b0, conf_trans_type};
      adv_g = {1'b0, conf_grp_sel} + 3'd1;
    end else begin
      adv_t = {1'b0, conf_trans_type} + 3'd1;
      adv_g = '0;
    end
    adv_pick = pick(adv_t, adv_g, eff_grp(conf_layer_type[0], grp_num_q),
                    a_num_q != '0, at_num_q != '0,
                    b_num_q != '0, bt_num_q != '0);
    adv_num  = seg_num(adv_pick[3:2], a_num_q, at_num_q, b_num_q, bt_num_q);

    offset_nxt = offset + ADDR_W'(conf_trans_num);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    cmd_done    = 1'b0;
    pe_start    = 1'b0;
    waddr_valid = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cap_pick[4] ? S_ADDR : S_DONE;
      end
      S_ADDR: begin
        waddr_valid = 1'b1;
        if (waddr_ready) state_nxt = S_START;
      end
      S_START: begin
        pe_start  = 1'b1;
        state_nxt = S_WAIT0;
      end
      // The packer still shows the previous done here; ignore it.
      S_WAIT0: state_nxt = S_WAIT;
      S_WAIT: begin
        if (pe_done) state_nxt = adv_pick[4] ? S_ADDR : S_DONE;
      end
      S_DONE: begin
        cmd_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Segment configuration is only loaded on the way into ADDR so the packer
  // sees stable values for the whole transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_num_q       <= '0;
      a_num_q         <= '0;
      at_num_q        <= '0;
      b_num_q         <= '0;
      bt_num_q        <= '0;
      base_q          <= '0;
      offset          <= '0;
      conf_layer_type <= '0;
      conf_trans_type <= '0;
      conf_trans_num  <= '0;
      conf_grp_sel    <= '0;
      waddr           <= '0;
      wlen            <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            grp_num_q       <= cmd_grp_num;
            a_num_q         <= cmd_a_num;
            at_num_q        <= cmd_at_num;
            b_num_q         <= cmd_b_num;
            bt_num_q        <= cmd_bt_num;
            base_q          <= cmd_base;
            offset          <= '0;
            conf_layer_type <= cmd_layer_type;
            conf_grp_sel    <= '0;
            if (cap_pick[4]) begin
              conf_trans_type <= cap_pick[3:2];
              conf_grp_sel    <= cap_pick[1:0];
              conf_trans_num  <= cap_num;
              waddr           <= cmd_base;
              wlen            <= cap_num;
            end
          end
        end
        S_WAIT: begin
          if (pe_done) begin
            offset <= offset_nxt;
            if (adv_pick[4]) begin
              conf_trans_type <= adv_pick[3:2];
              conf_grp_sel    <= adv_pick[1:0];
              conf_trans_num  <= adv_num;
              waddr           <= base_q + offset_nxt;
              wlen            <= adv_num;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe2ddr_sched.sv
module tb_pe2ddr_sched;

  localparam int ADDR_W = 32;
  localparam int NUM_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_layer_type = '0;
  logic [2:0]        cmd_grp_num = '0;
  logic [NUM_W-1:0]  cmd_a_num = '0;
  logic [NUM_W-1:0]  cmd_at_num = '0;
  logic [NUM_W-1:0]  cmd_b_num = '0;
  logic [NUM_W-1:0]  cmd_bt_num = '0;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic              cmd_done;
  logic              pe_start;
  logic              pe_done;
  logic [3:0]        conf_layer_type;
  logic [1:0]        conf_trans_type;
  logic [NUM_W-1:0]  conf_trans_num;
  logic [1:0]        conf_grp_sel;
  logic [ADDR_W-1:0] waddr;
  logic [NUM_W-1:0]  wlen;
  logic              waddr_valid;
  logic              waddr_ready;

  pe2ddr_sched #(.ADDR_W(ADDR_W), .NUM_W(NUM_W), .MAX_GRP(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_layer_type(cmd_layer_type), .cmd_grp_num(cmd_grp_num),
    .cmd_a_num(cmd_a_num), .cmd_at_num(cmd_at_num),
    .cmd_b_num(cmd_b_num), .cmd_bt_num(cmd_bt_num),
    .cmd_base(cmd_base), .cmd_done(cmd_done),
    .pe_start(pe_start), .pe_done(pe_done),
    .conf_layer_type(conf_layer_type), .conf_trans_type(conf_trans_type),
    .conf_trans_num(conf_trans_num), .conf_grp_sel(conf_grp_sel),
    .waddr(waddr), .wlen(wlen),
    .waddr_valid(waddr_valid), .waddr_ready(waddr_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0]        t;
    logic [1:0]        g;
    logic [NUM_W-1:0]  n;
    logic [ADDR_W-1:0] addr;
  } seg_t;

  seg_t sbq[$];
  logic [3:0] exp_lt;
  int exp_segs;

  // Reference segment list: back-to-back packing from the base address.
  task automatic build_expect(input logic [3:0] lt, input logic [2:0] gn,
                              input logic [NUM_W-1:0] a, input logic [NUM_W-1:0] at,
                              input logic [NUM_W-1:0] b, input logic [NUM_W-1:0] bt,
                              input logic [ADDR_W-1:0] base);
    int unsigned grps;
    logic [ADDR_W-1:0] off;
    seg_t s;
    grps = lt[0] ? int'(gn) : 1;
    off = '0;
    sbq.delete();
    if (a != 0)
      for (int unsigned g = 0; g < grps; g++) begin
        s.t = 2'd0; s.g = 2'(g); s.n = a; s.addr = base + off;
        sbq.push_back(s); off = off + ADDR_W'(a);
      end
    if (at != 0)
      for (int unsigned g = 0; g < grps; g++) begin
        s.t = 2'd1; s.g = 2'(g); s.n = at; s.addr = base + off;
        sbq.push_back(s); off = off + ADDR_W'(at);
      end
    if (b != 0) begin
      s.t = 2'd2; s.g = 2'd0; s.n = b; s.addr = base + off;
      sbq.push_back(s); off = off + ADDR_W'(b);
    end
    if (bt != 0) begin
      s.t = 2'd3; s.g = 2'd0; s.n = bt; s.addr = base + off;
      sbq.push_back(s);
    end
    exp_segs = sbq.size();
    exp_lt = lt;
  endtask

  // Packer model: done falls after start and rises pk_delay cycles later.
  // In stuck mode done stays high through the start and WAIT0 cycles.
  int pk_delay = 6;
  bit pk_stuck = 1'b0;
  int pk_cnt = 0;
  int pk_hold = 0;

  initial begin
    pe_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pk_cnt = 0; pk_hold = 0; pe_done = 1'b0;
      end else if (pe_start) begin
        pk_cnt = pk_delay;
        if (pk_stuck) begin
          pe_done = 1'b1; pk_hold = 2;
        end else pe_done = 1'b0;
      end else begin
        if (pk_hold > 0) begin
          pk_hold--;
          if (pk_hold == 0) pe_done = 1'b0;
        end
        if (pk_cnt > 0) begin
          pk_cnt--;
          if (pk_cnt == 0) pe_done = 1'b1;
        end
      end
    end
  end

  // Write-address slave: holds ready low for stall_req cycles of a request.
  int stall_req = 0;
  initial begin
    waddr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req > 0 && waddr_valid) begin
        waddr_ready = 1'b0; stall_req--;
      end else waddr_ready = 1'b1;
    end
  end

  // Output monitor and scoreboard.
  int starts = 0, dones = 0, stalls = 0;
  int last_start = 0, hs_cyc = 0, acc_cyc = 0;
  bit pend = 1'b0, prev_start = 1'b0;
  logic [ADDR_W-1:0] p_addr;
  logic [NUM_W-1:0]  p_len;

  always @(negedge clk) begin
    seg_t e;
    if (!rst) begin
      if (pe_start) begin
        chk("start_one_cycle", prev_start, 0);
        chk("start_after_hs", cyc - hs_cyc, 1);
        starts++;
        last_start = cyc;
      end
      if (waddr_valid) begin
        chk("busy_no_ready", cmd_ready, 0);
        if (pend) begin
          chk("hold_waddr", waddr, p_addr);
          chk("hold_wlen", wlen, p_len);
        end else if (starts > 0) begin
          chk("seg_gap", cyc - last_start, pk_delay + 1);
        end
        if (waddr_ready) begin
          pend = 1'b0;
          hs_cyc = cyc;
          if (sbq.size() == 0) chk("sb_extra_seg", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("waddr", waddr, e.addr);
            chk("wlen", wlen, e.n);
            chk("trans_type", conf_trans_type, e.t);
            chk("trans_num", conf_trans_num, e.n);
            chk("grp_sel", conf_grp_sel, e.g);
            chk("layer_type", conf_layer_type, exp_lt);
          end
        end else begin
          pend = 1'b1; p_addr = waddr; p_len = wlen; stalls++;
        end
      end else if (pend) begin
        chk("valid_dropped", 0, 1);
        pend = 1'b0;
      end
      if (cmd_done) begin
        dones++;
        if (starts > 0) chk("done_gap", cyc - last_start, pk_delay + 1);
        else chk("empty_done_lat", cyc - acc_cyc, 0);
      end
    end
    prev_start = pe_start;
  end

  task automatic issue(input logic [3:0] lt, input logic [2:0] gn,
                       input logic [NUM_W-1:0] a, input logic [NUM_W-1:0] at,
                       input logic [NUM_W-1:0] b, input logic [NUM_W-1:0] bt,
                       input logic [ADDR_W-1:0] base);
    build_expect(lt, gn, a, at, b, bt, base);
    starts = 0; dones = 0; stalls = 0; pend = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", cmd_ready, 1);
    cmd_layer_type = lt; cmd_grp_num = gn;
    cmd_a_num = a; cmd_at_num = at; cmd_b_num = b; cmd_bt_num = bt;
    cmd_base = base; cmd_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    // Scramble the fields: they must have been latched on accept.
    cmd_layer_type = 4'($urandom); cmd_grp_num = 3'($urandom);
    cmd_a_num = 8'($urandom); cmd_at_num = 8'($urandom);
    cmd_b_num = 8'($urandom); cmd_bt_num = 8'($urandom);
    cmd_base = $urandom;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (dones == 0 && n < budget) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_done_count"}, dones, 1);
    chk({tag, "_start_count"}, starts, exp_segs);
    chk({tag, "_sb_left"}, sbq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cmd_done", cmd_done, 0);
    chk("rst_pe_start", pe_start, 0);
    chk("rst_waddr_valid", waddr_valid, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wlen", wlen, 0);
    chk("rst_conf", {conf_layer_type, conf_trans_type, conf_trans_num, conf_grp_sel}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Summing layer: grp_num ignored, single AD segment
    pk_delay = 20;
    issue(4'd0, 3'd3, 8'd16, 8'd0, 8'd0, 8'd0, 32'h100);
    wait_done("sum", 300);

    // Per-group layer, plus a cmd_valid pulse while busy
    pk_delay = 6;
    issue(4'd1, 3'd3, 8'd8, 8'd2, 8'd4, 8'd1, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_layer_type = 4'd0; cmd_a_num = 8'd99; cmd_base = 32'h5555;
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_done("pergrp", 400);

    // Address channel stall
    stall_req = 5;
    issue(4'd0, 3'd1, 8'd5, 8'd0, 8'd0, 8'd0, 32'h40);
    wait_done("stall", 200);
    chk("stall_cycles", stalls, 5);

    // Done stuck high through WAIT0
    pk_stuck = 1'b1;
    issue(4'd1, 3'd2, 8'd4, 8'd0, 8'd0, 8'd0, 32'h200);
    wait_done("stuck", 200);
    pk_stuck = 1'b0;

    // All segments empty
    issue(4'd1, 3'd2, 8'd0, 8'd0, 8'd0, 8'd0, 32'h10);
    wait_done("empty", 50);

    // Reset during WAIT of the second segment
    pk_delay = 20;
    issue(4'd1, 3'd3, 8'd8, 8'd0, 8'd0, 8'd0, 32'h1000);
    n = 0;
    while (starts < 2 && n < 300) begin
      @(negedge clk); n++;
    end
    chk("abort_seg2_reached", starts, 2);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_waddr_valid", waddr_valid, 0);
    chk("abort_pe_start", pe_start, 0);
    chk("abort_waddr", waddr, 0);
    chk("abort_conf", {conf_layer_type, conf_trans_type, conf_trans_num, conf_grp_sel}, 0);
    sbq.delete();
    repeat (40) @(negedge clk);
    chk("abort_no_done", dones, 0);

    // Fresh command after abort, address wrap
    pk_delay = 6;
    issue(4'd1, 3'd2, 8'd16, 8'd0, 8'd0, 8'd0, 32'hFFFF_FFF8);
    wait_done("wrap", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
